// File: rtl/serial_link_gen.sv
// rtl/serial_link_gen.sv - parametrised link-port shift-register transceiver (SB/SC registers)
// Optional macro SERIAL_LINK_FAST_EN: SC bit1 becomes writable and selects DIV_FAST.
module serial_link_gen #(
   parameter int WIDTH    = 8,
   parameter int DIV_NORM = 256,
   parameter int DIV_FAST = 8
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             sel_sb,
   input  logic             sel_sc,
   input  logic             cpu_wr,
   input  logic             cpu_rd,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic             sck_in,
   input  logic             sin_in,
   output logic             sck_out,
   output logic             sck_dir,
   output logic             ser_out,
   output logic             int_serial
);
   localparam int DMAX = (DIV_NORM > DIV_FAST) ? DIV_NORM : DIV_FAST;
   localparam int DW   = $clog2(DMAX + 1);
   localparam int CW   = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN_LO, RUN_HI} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sb;
   logic             sc_start, sc_clksel, speed_rd;
   logic [CW-1:0]    cnt;
   logic [DW-1:0]    div_cnt, phase_div, wr_div, cur_div;
   logic [2:0]       sck_sync;
   logic             ext_rise, ext_fall, phase_end;
   logic             shift_en, out_en, done;
   logic             sc_wr, sb_wr;
   logic [7:0]       sc_val;

   assign sc_wr = cpu_wr & sel_sc;
   assign sb_wr = cpu_wr & sel_sb & (state == IDLE);

`ifdef SERIAL_LINK_FAST_EN
   logic sc_speed;
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         sc_speed <= 1'b0;
      else if (sc_wr)
         sc_speed <= din[1];
   end
   assign speed_rd = sc_speed;
   assign wr_div   = din[1]   ? DW'(DIV_FAST) : DW'(DIV_NORM);
   assign cur_div  = sc_speed ? DW'(DIV_FAST) : DW'(DIV_NORM);
`else
   assign speed_rd = 1'b1;
   assign wr_div   = DW'(DIV_NORM);
   assign cur_div  = DW'(DIV_NORM);
`endif

   // sck_sync[1:0] is the synchroniser, sck_sync[2] the previous synchronised level
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         sck_sync <= 3'b111;
      else
         sck_sync <= {sck_sync[1:0], sck_in};
   end
   assign ext_rise  = sck_sync[1] & ~sck_sync[2];
   assign ext_fall  = ~sck_sync[1] & sck_sync[2];
   assign phase_end = (div_cnt == (phase_div - DW'(1)));

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      shift_en = 1'b0;
      out_en   = 1'b0;
      done     = 1'b0;
      if (state != IDLE) begin
         if (sc_clksel) begin
            if (phase_end) begin
               if (state == RUN_LO) begin
                  state_nx = RUN_HI;
                  shift_en = 1'b1;
               end else if (cnt == '0) begin
                  state_nx = IDLE;
                  done     = 1'b1;
               end else begin
                  state_nx = RUN_LO;
                  out_en   = 1'b1;
               end
            end
         end else if (ext_rise) begin
            shift_en = 1'b1;
            if (cnt <= CW'(1)) begin
               state_nx = IDLE;
               done     = 1'b1;
            end else begin
               state_nx = RUN_HI;
            end
         end else if (ext_fall) begin
            state_nx = RUN_LO;
            out_en   = 1'b1;
         end
      end
      // A CPU write to SC overrides whatever the shifter decided this cycle
      if (sc_wr)
         state_nx = din[7] ? RUN_LO : IDLE;
   end

   always_comb begin
      sck_out = ~(sc_clksel && (state == RUN_LO));
      sck_dir = sc_clksel;
      sc_val  = {sc_start, 5'b11111, speed_rd, sc_clksel};
      dout    = '0;
      if (cpu_rd && sel_sb)
         dout = sb;
      else if (cpu_rd && sel_sc)
         dout = WIDTH'(sc_val);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sb         <= '0;
         sc_start   <= 1'b0;
         sc_clksel  <= 1'b0;
         cnt        <= '0;
         div_cnt    <= '0;
         phase_div  <= DW'(DIV_NORM);
         ser_out    <= 1'b1;
         int_serial <= 1'b0;
      end else begin
         int_serial <= done;
         if (sc_wr) begin
            sc_start  <= din[7];
            sc_clksel <= din[0];
            if (din[7]) begin
               cnt       <= CW'(WIDTH);
               div_cnt   <= '0;
               phase_div <= wr_div;
               ser_out   <= sb[WIDTH-1];
            end
         end else begin
            if (done)
               sc_start <= 1'b0;
            if ((state != IDLE) && sc_clksel) begin
               if (phase_end) begin
                  div_cnt   <= '0;
                  phase_div <= cur_div;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            if (shift_en) begin
               sb  <= {sb[WIDTH-2:0], sin_in};
               cnt <= (cnt == '0) ? '0 : cnt - CW'(1);
            end
            if (out_en)
               ser_out <= sb[WIDTH-1];
         end
         if (sb_wr)
            sb <= din;
      end
   end
endmodule
